soc_system_pio_in_edge: RTL and testbench

SOC_SYSTEM_PIO_IN_EDGE -- requirements
Module: soc_system_pio_in_edge

---
 rtl/soc_system_pio_in_edge.sv | 123 ++++++++++++
 tb/tb_soc_system_pio_in_edge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_in_edge.sv
// rtl/soc_system_pio_in_edge.sv - debounced, edge-capturing parallel input port with Avalon-MM slave
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   address      Avalon-MM word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data, only [WIDTH-1:0] used
//   in_port      asynchronous external inputs
//   readdata     registered read data, one cycle latency, upper bits zero
//   irq          registered level interrupt: OR(edgecapture & irqmask)
module soc_system_pio_in_edge #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Synchroniser chain: stage 0 samples the pins, the last stage feeds everything else.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign acc_d = synced;
    end else begin : g_debounce
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic          differs;
        assign differs = (synced[b] != acc_q[b]);

        // Count consecutive cycles of disagreement; any agreement restarts it,
        // and acceptance on the last count restarts it as well.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_q <= '0;
          end else if (!differs || (cnt_q == LAST)) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        assign acc_d[b] = (differs && (cnt_q == LAST)) ? synced[b] : acc_q[b];
      end
    end
  endgenerate

  logic [WIDTH-1:0] edge_set;

  always_comb begin
    edge_set = '0;
    case (EDGE_TYPE)
      0:       edge_set = acc_d & ~acc_q;
      1:       edge_set = ~acc_d & acc_q;
      default: edge_set = acc_d ^ acc_q;
    endcase
  end

  logic             wr_en;
  logic [WIDTH-1:0] ec_clr;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] ec_q;
  logic [31:0]      rd_d;

  assign wr_en  = chipselect && !write_n;
  assign ec_clr = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_d = '0;
    case (address)
      2'd0:    rd_d[WIDTH-1:0] = acc_q;
      2'd2:    rd_d[WIDTH-1:0] = mask_q;
      2'd3:    rd_d[WIDTH-1:0] = ec_q;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mask_q   <= '0;
      ec_q     <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (wr_en && (address == 2'd2)) mask_q <= writedata[WIDTH-1:0];
      // A fresh edge wins over a simultaneous write-1-to-clear of the same bit.
      ec_q     <= (ec_q & ~ec_clr) | edge_set;
      readdata <= rd_d;
      irq      <= |(ec_q & mask_q);
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// tb/tb_soc_system_pio_in_edge.sv - self-checking bench for soc_system_pio_in_edge
module tb_soc_system_pio_in_edge;

  localparam int W = 10;
  localparam int S = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  addr_a, addr_b;
  logic        cs_a, cs_b, wn_a, wn_b;
  logic [31:0] wd_a, wd_b;
  logic [W-1:0] in_a;
  logic [31:0] in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_system_pio_in_edge dut_a (
    .clk(clk), .reset_n(reset_n), .address(addr_a), .chipselect(cs_a),
    .write_n(wn_a), .writedata(wd_a), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  soc_system_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(addr_b), .chipselect(cs_b),
    .write_n(wn_b), .writedata(wd_b), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  // Reference model for dut_a: pin samples are logged per clock edge; the value
  // seen after synchronisation is simply the sample S edges earlier, and a bit
  // is accepted once D consecutive such values all disagree with it.
  logic [W-1:0] in_log [0:4095];
  int           n = 0;
  int           rst_edge = 0;
  logic [W-1:0] m_acc = '0, m_mask = '0, m_ec = '0;

  function automatic logic [W-1:0] sval(input int k);
    if (k < 0 || k < rst_edge) return '0;
    return in_log[k];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [W-1:0] nacc, rise, clr, sv;
    logic [31:0]  rde;
    logic         irqe;
    logic         all_diff;
    @(posedge clk);
    n++;
    in_log[n] = in_a;
    rde  = '0;
    irqe = 1'b0;
    if (!reset_n) begin
      m_acc = '0; m_mask = '0; m_ec = '0;
      rst_edge = n + 1;
    end else begin
      nacc = m_acc;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          sv = sval(n - S - j);
          if (sv[b] == m_acc[b]) all_diff = 1'b0;
        end
        if (all_diff) nacc[b] = ~m_acc[b];
      end
      rise = nacc & ~m_acc;
      case (addr_a)
        2'd0: rde = {22'd0, m_acc};
        2'd2: rde = {22'd0, m_mask};
        2'd3: rde = {22'd0, m_ec};
        default: rde = '0;
      endcase
      irqe = |(m_ec & m_mask);
      clr = (cs_a && !wn_a && addr_a == 2'd3) ? wd_a[W-1:0] : '0;
      if (cs_a && !wn_a && addr_a == 2'd2) m_mask = wd_a[W-1:0];
      m_ec  = (m_ec & ~clr) | rise;
      m_acc = nacc;
    end
    #1;
    chk("model_readdata", rd_a, rde);
    chk("model_irq", {31'd0, irq_a}, {31'd0, irqe});
  endtask

  task automatic idle_a(input logic [1:0] a);
    cs_a = 1'b0; wn_a = 1'b1; wd_a = '0; addr_a = a;
  endtask

  task automatic write_a(input logic [1:0] a, input logic [31:0] d);
    cs_a = 1'b1; wn_a = 1'b0; wd_a = d; addr_a = a;
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    idle_a(2'd0);
    in_a = '0;
    cs_b = 1'b0; wn_b = 1'b1; wd_b = '0; addr_b = 2'd0; in_b = '0;
    #2;
    chk("reset_rd_a", rd_a, 32'h0);
    chk("reset_irq_a", {31'd0, irq_a}, 32'h0);
    chk("reset_rd_b", rd_b, 32'h0);
    repeat (3) cyc();
    reset_n = 1'b1;

    // Held input accepted after sync + debounce, edge captured.
    in_a = 10'h155;
    repeat (7) cyc();
    chk("accept_0x155", rd_a, 32'h155);
    idle_a(2'd3);
    cyc();
    chk("edgecap_0x155", rd_a, 32'h155);
    write_a(2'd3, 32'h3FF);
    cyc();
    idle_a(2'd3);
    in_a = '0;
    repeat (8) cyc();
    chk("falling_not_captured", rd_a, 32'h0);

    // Short glitch must be rejected.
    in_a = 10'h008;
    repeat (3) cyc();
    in_a = '0;
    idle_a(2'd0);
    repeat (10) cyc();
    chk("glitch_acc", rd_a, 32'h0);
    idle_a(2'd3);
    cyc();
    chk("glitch_edgecap", rd_a, 32'h0);

    // Masked interrupt from bit 3, then clear.
    write_a(2'd2, 32'h008);
    cyc();
    idle_a(2'd3);
    in_a = 10'h008;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (rd_a[3]) found = 1'b1;
    end
    chk("edgecap3_seen", {31'd0, found}, 32'h1);
    chk("irq_with_edgecap3", {31'd0, irq_a}, 32'h1);
    write_a(2'd3, 32'h008);
    cyc();
    idle_a(2'd3);
    cyc();
    chk("edgecap_cleared", rd_a, 32'h0);
    chk("irq_cleared", {31'd0, irq_a}, 32'h0);

    // Edge on bit 0 lands on the same edge as a clear of bit 0.
    in_a = 10'h009;
    repeat (5) cyc();
    write_a(2'd3, 32'h001);
    cyc();
    idle_a(2'd3);
    cyc();
    chk("set_beats_clear", rd_a & 32'h1, 32'h1);

    // Asynchronous reset mid-debounce and with irq asserted.
    write_a(2'd2, 32'h3FF);
    cyc();
    idle_a(2'd3);
    cyc();
    chk("irq_before_reset", {31'd0, irq_a}, 32'h1);
    in_a = '0;
    repeat (3) cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_rd", rd_a, 32'h0);
    chk("async_reset_irq", {31'd0, irq_a}, 32'h0);
    in_a = 10'h3FF;
    repeat (3) cyc();
    reset_n = 1'b1;
    idle_a(2'd3);
    repeat (8) cyc();
    chk("held_through_reset", rd_a, 32'h3FF);

    // Falling-edge, no-debounce, full-width instance.
    in_b = 32'hFFFF_FFFF; addr_b = 2'd3;
    repeat (6) cyc();
    chk("b_rising_ignored", rd_b, 32'h0);
    addr_b = 2'd0;
    cyc();
    chk("b_acc_ones", rd_b, 32'hFFFF_FFFF);
    addr_b = 2'd3; in_b = '0;
    for (int i = 1; i <= S + 1; i++) begin
      cyc();
      chk("b_not_yet", rd_b, 32'h0);
    end
    cyc();
    chk("b_falling_all", rd_b, 32'hFFFF_FFFF);
    chk("b_irq_unmasked", {31'd0, irq_b}, 32'h0);
    cs_b = 1'b1; wn_b = 1'b0; wd_b = 32'hFFFF_FFFF; addr_b = 2'd1;
    cyc();
    chk("b_reserved_rd", rd_b, 32'h0);
    cs_b = 1'b0; wn_b = 1'b1;
    cyc();
    chk("b_reserved_after_wr", rd_b, 32'h0);
    cs_b = 1'b1; wn_b = 1'b0; addr_b = 2'd3;
    cyc();
    cs_b = 1'b0; wn_b = 1'b1;
    cyc();
    chk("b_edgecap_cleared", rd_b, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cs_a   = 1'($urandom_range(0, 1));
      wn_a   = 1'($urandom_range(0, 1));
      addr_a = 2'($urandom_range(0, 3));
      wd_a   = $urandom;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) in_a[b] = ~in_a[b];
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
